serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in on start and
// adds them LSB first, one bit per clock, presenting the registered sum on completion.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             bit_sum;
  logic             bit_carry;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    carry_d   = carry_q;
    done_d    = done_q;
    busy_d    = busy_q;
    bit_sum   = a_q[0] ^ b_q[0] ^ c_q;
    bit_carry = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_op1;
          b_d     = i_op2;
          c_d     = i_carry;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_carry;
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        sum_d = sum_q >> 1;
        sum_d[WIDTH-1] = bit_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          res_d   = sum_d;
          carry_d = bit_carry;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_res   = res_q;
  assign o_carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, operand-change and
// mid-run reset sequences, random vectors and an exhaustive back-to-back sweep.
module tb_serial_adder;

  localparam int W = 4;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic         i_carry;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_res;
  logic         o_carry;

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_op1  (i_op1),
    .i_op2  (i_op2),
    .i_carry(i_carry),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_res  (o_res),
    .o_carry(o_carry)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts one addition from IDLE (called #1 after an edge), waits for done,
  // then steps through the DONE cycle so the caller is back in IDLE.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit meddle, output logic [W-1:0] res, output logic cout,
                        output int lat, output int busy_cnt, output bit hold_ok);
    logic [W-1:0] old_res;
    logic         old_c;
    old_res  = o_res;
    old_c    = o_carry;
    hold_ok  = 1'b1;
    i_op1    = a;
    i_op2    = b;
    i_carry  = c;
    i_start  = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!o_done && lat < 20) begin
      if (o_busy) busy_cnt++;
      if (o_res !== old_res || o_carry !== old_c) hold_ok = 1'b0;
      if (meddle) begin
        i_start = 1'b1;
        i_op1   = W'($urandom);
        i_op2   = W'($urandom);
        i_carry = 1'($urandom);
      end
      @(posedge i_clk); #1;
      lat++;
    end
    if (o_busy) busy_cnt++;
    i_start = 1'b0;
    res     = o_res;
    cout    = o_carry;
    @(posedge i_clk); #1;
    check("done_one_cycle", int'(o_done), 0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic         co;
    int           lat;
    int           bc;
    bit           hold;
    int           exp_sum;
    int           got;
    int           guard;
    int           done_seen;
    int           exp_q[$];

    tbl[0] = '{4'd4,  4'd5,  1'b0, 4'd9,  1'b0};
    tbl[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
    tbl[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    tbl[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    tbl[4] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
    tbl[5] = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1};
    tbl[6] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};
    tbl[7] = '{4'd9,  4'd9,  1'b1, 4'd3,  1'b1};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_op1   = '0;
    i_op2   = '0;
    i_carry = 1'b0;
    #1;
    check("reset_busy",  int'(o_busy),  0);
    check("reset_done",  int'(o_done),  0);
    check("reset_res",   int'(o_res),   0);
    check("reset_carry", int'(o_carry), 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed table, including latency, busy duration and output hold
    for (int k = 0; k < 8; k++) begin
      do_add(tbl[k].op1, tbl[k].op2, tbl[k].cin, 1'b0, r, co, lat, bc, hold);
      check("tbl_res",     int'(r),  int'(tbl[k].res));
      check("tbl_carry",   int'(co), int'(tbl[k].cout));
      check("tbl_latency", lat, W);
      check("tbl_busy",    bc,  W);
      check("tbl_hold",    int'(hold), 1);
    end

    // Start and operand changes during RUN are ignored
    do_add(4'd3, 4'd2, 1'b0, 1'b1, r, co, lat, bc, hold);
    check("ignore_res",   int'(r),  5);
    check("ignore_carry", int'(co), 0);
    check("ignore_hold",  int'(hold), 1);
    check("ignore_lat",   lat, W);

    // Random operands against plain integer addition
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      c = 1'($urandom_range(0, 1));
      exp_sum = int'(a) + int'(b) + int'(c);
      do_add(a, b, c, 1'b0, r, co, lat, bc, hold);
      check("rand_sum", int'({co, r}), exp_sum);
      check("rand_lat", lat, W);
    end

    // Reset mid-RUN aborts and clears outputs immediately
    do_add(4'd3, 4'd3, 1'b0, 1'b0, r, co, lat, bc, hold);
    check("pre_reset_res", int'(r), 6);
    i_op1 = 4'd7; i_op2 = 4'd8; i_carry = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    check("abort_res",   int'(o_res),   0);
    check("abort_carry", int'(o_carry), 0);
    check("abort_busy",  int'(o_busy),  0);
    check("abort_done",  int'(o_done),  0);
    done_seen = 0;
    repeat (6) begin
      @(posedge i_clk); #1;
      if (o_done) done_seen++;
      if (k_release_now(done_seen)) ;
    end
    i_rst_n = 1'b1;
    repeat (6) begin
      @(posedge i_clk); #1;
      if (o_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    do_add(4'd6, 4'd1, 1'b0, 1'b0, r, co, lat, bc, hold);
    check("post_reset_res",   int'(r),  7);
    check("post_reset_carry", int'(co), 0);
    check("post_reset_lat",   lat, W);

    // Exhaustive sweep, back-to-back with start held high
    got   = 0;
    guard = 0;
    i_op1 = '0; i_op2 = '0; i_carry = 1'b0;
    exp_q.push_back(0);
    i_start = 1'b1;
    while (got < 512 && guard < 512 * 8) begin
      @(posedge i_clk); #1;
      guard++;
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("exh_unexpected_done", 1, 0);
        end else begin
          exp_sum = exp_q.pop_front();
          check("exh_sum", int'({o_carry, o_res}), exp_sum);
        end
        got++;
        if (got < 512) begin
          i_carry = 1'(got >> 8);
          i_op1   = W'((got >> 4) & 15);
          i_op2   = W'(got & 15);
          exp_q.push_back(int'(i_op1) + int'(i_op2) + int'(i_carry));
        end else begin
          i_start = 1'b0;
        end
      end
    end
    i_start = 1'b0;
    check("exh_count", got, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic bit k_release_now(input int d);
    return d < 0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
